// File: rtl/filter_test_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : filter_test_sequencer_if
// Purpose  : Bundles the test-control and datapath signals of the filter test
//            sequencer into one interface.
//   master : test controller / datapath side (drives start, abort, cfg_*,
//            filter_sel, filter_data_bus; observes results and test_*)
//   slave  : the sequencer itself
// Revision : 1.0 - initial release
// ============================================================================
interface filter_test_sequencer_if #(
  parameter int SIZE_DELAY       = 8,
  parameter int SIZE_FILTER_DATA = 16,
  parameter int NUM_FILTERS      = 21,
  parameter int SEL_W            = 5,
  parameter int WIN_W            = 8
);
  logic                                    start;
  logic                                    abort;
  logic [SIZE_DELAY-1:0]                   cfg_delay_base;
  logic [SIZE_DELAY-1:0]                   cfg_delay_step;
  logic [WIN_W-1:0]                        cfg_windows;
  logic [SEL_W-1:0]                        filter_sel;
  logic [NUM_FILTERS*SIZE_FILTER_DATA-1:0] filter_data_bus;
  logic                                    test_overlay;
  logic                                    test_rate;
  logic [SIZE_DELAY-1:0]                   test_delay;
  logic [SIZE_FILTER_DATA-1:0]             peak_data;
  logic [SIZE_FILTER_DATA-1:0]             min_data;
  logic [1:0]                              peak_case;
  logic                                    peak_valid;
  logic                                    busy;
  logic                                    done;

  modport master (
    output start, abort, cfg_delay_base, cfg_delay_step, cfg_windows,
           filter_sel, filter_data_bus,
    input  test_overlay, test_rate, test_delay, peak_data, min_data,
           peak_case, peak_valid, busy, done
  );

  modport slave (
    input  start, abort, cfg_delay_base, cfg_delay_step, cfg_windows,
           filter_sel, filter_data_bus,
    output test_overlay, test_rate, test_delay, peak_data, min_data,
           peak_case, peak_valid, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/filter_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : filter_test_sequencer
// Purpose  : Steps the signal generator through four test cases
//            (overlay/rate = case index bits, delay = base + idx*step,
//            saturating), waits for the filters to settle, then reports the
//            signed peak of one filter channel per measurement window.
// Ports    : clk, reset (sync, active-low), seq_if (slave modport):
//            start/abort pulses, cfg_* and filter_sel (latched at start),
//            filter_data_bus in; test_* controls, peak_data/min_data,
//            peak_case, peak_valid, busy, done out.
// Option   : FILTER_SEQ_MIN_TRACK_EN - adds a running signed minimum on
//            min_data; otherwise min_data is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module filter_test_sequencer #(
  parameter int SIZE_DELAY       = 8,
  parameter int SIZE_FILTER_DATA = 16,
  parameter int NUM_FILTERS      = 21,
  parameter int SEL_W            = 5,
  parameter int SETTLE_CYCLES    = 32,
  parameter int WINDOW_LEN       = 64,
  parameter int WIN_W            = 8
) (
  input  wire logic              clk,
  input  wire logic              reset,
  filter_test_sequencer_if.slave seq_if
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_MEASURE = 3'd2,
    S_REPORT  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam int c_cnt_max = (SETTLE_CYCLES > WINDOW_LEN) ? SETTLE_CYCLES : WINDOW_LEN;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam logic [SIZE_FILTER_DATA-1:0] c_most_neg = {1'b1, {(SIZE_FILTER_DATA-1){1'b0}}};

  state_t                       r_state;
  logic [1:0]                   r_case;
  logic [WIN_W-1:0]             r_win;        // windows completed in current case
  logic [c_cnt_w-1:0]           r_cnt;
  logic [SIZE_DELAY-1:0]        r_cfg_base;
  logic [SIZE_DELAY-1:0]        r_cfg_step;
  logic [WIN_W-1:0]             r_cfg_windows;
  logic [SEL_W-1:0]             r_sel;
  logic signed [SIZE_FILTER_DATA-1:0] r_peak;
  logic                         r_test_overlay;
  logic                         r_test_rate;
  logic [SIZE_DELAY-1:0]        r_test_delay;
  logic [SIZE_FILTER_DATA-1:0]  r_peak_data;
  logic [1:0]                   r_peak_case;
  logic                         r_peak_valid;
  logic                         r_done;

  logic signed [SIZE_FILTER_DATA-1:0] w_sample;
  logic signed [SIZE_FILTER_DATA-1:0] w_next_peak;
  logic [1:0]                         w_case_nxt;

  // Out-of-range selects were already folded to channel 0 when latched.
  assign w_sample    = seq_if.filter_data_bus[int'(r_sel)*SIZE_FILTER_DATA +: SIZE_FILTER_DATA];
  assign w_next_peak = (w_sample > r_peak) ? w_sample : r_peak;
  assign w_case_nxt  = r_case + 2'd1;

  // Sum is formed two bits wider than the delay so overflow is visible and
  // clamps to all-ones instead of wrapping.
  function automatic logic [SIZE_DELAY-1:0] f_case_delay(
    input logic [SIZE_DELAY-1:0] base,
    input logic [SIZE_DELAY-1:0] step,
    input logic [1:0]            idx
  );
    logic [SIZE_DELAY+1:0] sum;
    sum = {2'b00, base} + ({2'b00, step} * {{SIZE_DELAY{1'b0}}, idx});
    if (sum[SIZE_DELAY+1 -: 2] != 2'b00) return '1;
    return sum[SIZE_DELAY-1:0];
  endfunction

`ifdef FILTER_SEQ_MIN_TRACK_EN
  localparam logic [SIZE_FILTER_DATA-1:0] c_most_pos = {1'b0, {(SIZE_FILTER_DATA-1){1'b1}}};
  logic signed [SIZE_FILTER_DATA-1:0] r_min;
  logic [SIZE_FILTER_DATA-1:0]        r_min_data;
  logic signed [SIZE_FILTER_DATA-1:0] w_next_min;
  assign w_next_min      = (w_sample < r_min) ? w_sample : r_min;
  assign seq_if.min_data = r_min_data;
`else
  assign seq_if.min_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_case         <= '0;
      r_win          <= '0;
      r_cnt          <= '0;
      r_cfg_base     <= '0;
      r_cfg_step     <= '0;
      r_cfg_windows  <= '0;
      r_sel          <= '0;
      r_peak         <= '0;
      r_test_overlay <= 1'b0;
      r_test_rate    <= 1'b0;
      r_test_delay   <= '0;
      r_peak_data    <= '0;
      r_peak_case    <= '0;
      r_peak_valid   <= 1'b0;
      r_done         <= 1'b0;
`ifdef FILTER_SEQ_MIN_TRACK_EN
      r_min          <= '0;
      r_min_data     <= '0;
`endif
    end else begin
      r_peak_valid <= 1'b0;
      r_done       <= 1'b0;
      // Abort outranks everything, including the result strobe that would
      // otherwise be raised on the last measured sample.
      if (seq_if.abort && (r_state != S_IDLE)) begin
        r_state        <= S_IDLE;
        r_case         <= '0;
        r_win          <= '0;
        r_cnt          <= '0;
        r_test_overlay <= 1'b0;
        r_test_rate    <= 1'b0;
        r_test_delay   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (seq_if.start && !seq_if.abort) begin
              r_cfg_base     <= seq_if.cfg_delay_base;
              r_cfg_step     <= seq_if.cfg_delay_step;
              r_cfg_windows  <= (seq_if.cfg_windows == '0) ? {{(WIN_W-1){1'b0}}, 1'b1}
                                                           : seq_if.cfg_windows;
              r_sel          <= (int'(seq_if.filter_sel) < NUM_FILTERS) ? seq_if.filter_sel : '0;
              r_case         <= '0;
              r_win          <= '0;
              r_cnt          <= '0;
              r_test_overlay <= 1'b0;
              r_test_rate    <= 1'b0;
              r_test_delay   <= seq_if.cfg_delay_base;  // case 0 never overflows
              r_state        <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            r_peak <= c_most_neg;
`ifdef FILTER_SEQ_MIN_TRACK_EN
            r_min  <= c_most_pos;
`endif
            if (r_cnt == c_cnt_w'(SETTLE_CYCLES - 1)) begin
              r_cnt   <= '0;
              r_state <= S_MEASURE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_MEASURE: begin
            r_peak <= w_next_peak;
`ifdef FILTER_SEQ_MIN_TRACK_EN
            r_min  <= w_next_min;
`endif
            if (r_cnt == c_cnt_w'(WINDOW_LEN - 1)) begin
              // Result includes this final sample.
              r_cnt        <= '0;
              r_win        <= r_win + 1'b1;
              r_peak_data  <= w_next_peak;
              r_peak_case  <= r_case;
              r_peak_valid <= 1'b1;
`ifdef FILTER_SEQ_MIN_TRACK_EN
              r_min_data   <= w_next_min;
`endif
              r_state      <= S_REPORT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_REPORT: begin
            r_peak <= c_most_neg;
`ifdef FILTER_SEQ_MIN_TRACK_EN
            r_min  <= c_most_pos;
`endif
            if (r_win < r_cfg_windows) begin
              r_state <= S_MEASURE;
            end else if (r_case != 2'd3) begin
              r_case         <= w_case_nxt;
              r_win          <= '0;
              r_test_overlay <= w_case_nxt[1];
              r_test_rate    <= w_case_nxt[0];
              r_test_delay   <= f_case_delay(r_cfg_base, r_cfg_step, w_case_nxt);
              r_state        <= S_SETTLE;
            end else begin
              r_done         <= 1'b1;
              r_test_overlay <= 1'b0;
              r_test_rate    <= 1'b0;
              r_test_delay   <= '0;
              r_state        <= S_DONE;
            end
          end
          S_DONE: begin
            r_case  <= '0;
            r_win   <= '0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign seq_if.test_overlay = r_test_overlay;
  assign seq_if.test_rate    = r_test_rate;
  assign seq_if.test_delay   = r_test_delay;
  assign seq_if.peak_data    = r_peak_data;
  assign seq_if.peak_case    = r_peak_case;
  assign seq_if.peak_valid   = r_peak_valid;
  assign seq_if.done         = r_done;
  assign seq_if.busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_filter_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_filter_test_sequencer
// Purpose  : Self-checking bench for filter_test_sequencer. A cycle-indexed
//            timing model derived from the case/window schedule predicts
//            every strobe, the test_* controls and the signed window extrema.
// Revision : 1.0 - initial release
// ============================================================================
module tb_filter_test_sequencer;
  localparam int SD = 8;
  localparam int FW = 16;
  localparam int NF = 21;
  localparam int SW = 5;
  localparam int ST = 32;
  localparam int WL = 64;
  localparam int WW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  filter_test_sequencer_if #(
    .SIZE_DELAY(SD), .SIZE_FILTER_DATA(FW), .NUM_FILTERS(NF), .SEL_W(SW), .WIN_W(WW)
  ) seq_if ();

  filter_test_sequencer #(
    .SIZE_DELAY(SD), .SIZE_FILTER_DATA(FW), .NUM_FILTERS(NF), .SEL_W(SW),
    .SETTLE_CYCLES(ST), .WINDOW_LEN(WL), .WIN_W(WW)
  ) u_dut (
    .clk    (clk),
    .reset  (reset),
    .seq_if (seq_if.slave)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic randomize_bus();
    for (int c = 0; c < NF; c++) seq_if.filter_data_bus[c*FW +: FW] = FW'($urandom);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  32'(seq_if.busy), 32'd0);
    check({tag, "_valid"}, 32'(seq_if.peak_valid), 32'd0);
    check({tag, "_done"},  32'(seq_if.done), 32'd0);
    check({tag, "_ctl"},   {22'd0, seq_if.test_overlay, seq_if.test_rate, seq_if.test_delay}, 32'd0);
  endtask

  // mode 0: random, 1: constant cval, 2: ramp -300..200 in case 0 window 0
  task automatic run_seq(input int base, input int step, input int win, input int sel,
                         input int mode, input int cval, input int abort_at, input bit noise);
    int w_eff, P, ch, stop, p, ci, r, pos, wi, d;
    bit alive, in_case, exp_valid;
    logic signed [FW-1:0] v, emax, emin;
    w_eff = (win == 0) ? 1 : win;
    P     = ST + w_eff * (WL + 1);
    ch    = (sel < NF) ? sel : 0;
    stop  = (abort_at > 0) ? abort_at + 8 : 4 * P + 3;
    emax  = '0;
    emin  = '0;

    @(negedge clk);
    seq_if.cfg_delay_base = SD'(base);
    seq_if.cfg_delay_step = SD'(step);
    seq_if.cfg_windows    = WW'(win);
    seq_if.filter_sel     = SW'(sel);
    seq_if.start          = 1'b1;
    seq_if.abort          = 1'b0;
    randomize_bus();

    for (int k = 1; k <= stop; k++) begin
      @(negedge clk);
      seq_if.start = noise && (k < 4 * P) && ($urandom_range(0, 7) == 0);
      seq_if.abort = (k == abort_at);
      if (noise && k > 1) begin
        seq_if.cfg_delay_base = SD'($urandom);
        seq_if.cfg_delay_step = SD'($urandom);
        seq_if.cfg_windows    = WW'($urandom);
        seq_if.filter_sel     = SW'($urandom);
      end

      alive   = ((abort_at == 0) || (k <= abort_at)) && (k <= 4 * P + 1);
      in_case = alive && (k <= 4 * P);
      p  = k - 1;
      ci = p / P;
      r  = p % P;
      pos = -1;
      wi  = 0;
      if (in_case && r >= ST) begin
        pos = (r - ST) % (WL + 1);
        wi  = (r - ST) / (WL + 1);
      end
      exp_valid = in_case && (pos == WL);

      check("busy",  32'(seq_if.busy), 32'(alive));
      check("valid", 32'(seq_if.peak_valid), 32'(exp_valid));
      check("done",  32'(seq_if.done), 32'(alive && (k == 4 * P + 1)));
      d = base + ci * step;
      if (d > 255) d = 255;
      check("ctl", {22'd0, seq_if.test_overlay, seq_if.test_rate, seq_if.test_delay},
            in_case ? 32'((ci << SD) | d) : 32'd0);
      if (exp_valid) begin
        check("peak_data", {16'd0, seq_if.peak_data}, {16'd0, emax});
        check("peak_case", 32'(seq_if.peak_case), 32'(ci));
`ifdef FILTER_SEQ_MIN_TRACK_EN
        check("min_data", {16'd0, seq_if.min_data}, {16'd0, emin});
`else
        check("min_data", {16'd0, seq_if.min_data}, 32'd0);
`endif
      end

      randomize_bus();
      case (mode)
        1:       v = FW'(cval);
        2:       v = (ci == 0 && wi == 0 && pos >= 0 && pos < WL) ? FW'(-300 + (pos * 500) / (WL - 1))
                                                                  : FW'($urandom);
        default: v = FW'($urandom);
      endcase
      seq_if.filter_data_bus[ch*FW +: FW] = v;
      if (pos >= 0 && pos < WL) begin
        if (pos == 0 || v > emax) emax = v;
        if (pos == 0 || v < emin) emin = v;
      end
    end
    seq_if.start = 1'b0;
    seq_if.abort = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    seq_if.start = 1'b0;
    seq_if.abort = 1'b0;
    seq_if.cfg_delay_base = '0;
    seq_if.cfg_delay_step = '0;
    seq_if.cfg_windows    = '0;
    seq_if.filter_sel     = '0;
    seq_if.filter_data_bus = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_peak", {16'd0, seq_if.peak_data}, 32'd0);
    check("reset_case", 32'(seq_if.peak_case), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_seq(10, 5, 1, 2, 1, 'h0100, 0, 1'b0);     // basic 4-case sweep
    run_seq(0, 0, 1, 2, 2, 0, 0, 1'b0);           // ramp -300..200
    run_seq(7, 1, 1, 2, 1, -5, 0, 1'b0);          // negative-only window
    run_seq(250, 3, 1, $urandom_range(0, NF-1), 0, 0, 0, 1'b0);  // saturation
    run_seq($urandom_range(0, 255), $urandom_range(0, 255), 3, $urandom_range(0, NF-1), 0, 0, 0, 1'b0);
    // abort in case 1 MEASURE (P = 97 for one window)
    run_seq(20, 4, 1, 5, 0, 0, 1 + 97 + ST + 10, 1'b0);
    run_seq(20, 4, 1, 5, 0, 0, 0, 1'b0);
    // noisy start/cfg while busy, windows=0, out-of-range select
    run_seq(30, 9, 0, 25, 0, 0, 0, 1'b1);

    // start and abort together while idle
    @(negedge clk);
    seq_if.start = 1'b1;
    seq_if.abort = 1'b1;
    @(negedge clk);
    seq_if.start = 1'b0;
    seq_if.abort = 1'b0;
    check_idle_outputs("start_abort");

    // reset mid-run clears results as well
    seq_if.cfg_windows = 8'd2;
    seq_if.start = 1'b1;
    @(negedge clk);
    seq_if.start = 1'b0;
    repeat (150) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_idle_outputs("mid_reset");
    check("mid_reset_peak", {16'd0, seq_if.peak_data}, 32'd0);
    check("mid_reset_case", 32'(seq_if.peak_case), 32'd0);

    run_seq($urandom_range(0, 255), $urandom_range(0, 255), 2, $urandom_range(0, 31), 0, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/filter_test_sequencer.md
Name: filter_test_sequencer

Overview:
- Sequences the test-signal generator's `overlay`, `rate` and `delay` controls through four fixed test cases.
- Waits for the filter pipelines to settle, then measures the peak of one selected filter output over timed windows.
- Reports one peak per window and runs autonomously after a `start` pulse.
- Sits between the top-level test control and the signal-generator/filter-bank datapath.

Parameters:
- SIZE_DELAY, 8: width of the delay control.
- SIZE_FILTER_DATA, 16: width of each filter output, two's-complement signed.
- NUM_FILTERS, 21: number of filter channels on the input bus.
- SEL_W, 5: width of the filter select.
- SETTLE_CYCLES, 32: cycles waited after a parameter change before measuring.
- WINDOW_LEN, 64: cycles per measurement window.
- WIN_W, 8: width of the window-count configuration.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle start pulse; honoured only in IDLE
- abort  in  1  one-cycle abort pulse
- cfg_delay_base  in  SIZE_DELAY  delay for case 0
- cfg_delay_step  in  SIZE_DELAY  delay increment per case
- cfg_windows  in  WIN_W  windows per case; 0 is treated as 1
- filter_sel  in  SEL_W  filter channel to measure
- filter_data_bus  in  NUM_FILTERS*SIZE_FILTER_DATA  packed filter outputs; channel k occupies bits [k*SIZE_FILTER_DATA +: SIZE_FILTER_DATA]
- test_overlay  out  1  to signal generator
- test_rate  out  1  to signal generator
- test_delay  out  SIZE_DELAY  to signal generator
- peak_data  out  SIZE_FILTER_DATA  signed window maximum
- min_data  out  SIZE_FILTER_DATA  signed window minimum (optional feature)
- peak_case  out  2  case index of the reported window
- peak_valid  out  1  one-cycle result strobe
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion strobe

Behaviour:
- Reset (reset=0 at a clk edge):
  - State returns to IDLE.
  - All outputs go to 0 and all counters clear.
- Configuration latching:
  - cfg_*, filter_sel are latched on the cycle start is accepted.
  - Later changes to these inputs have no effect until the next run.
- Case table, indexed by case_idx 0..3:
  - test_overlay = case_idx[1]; test_rate = case_idx[0].
  - test_delay = base + case_idx*step, computed at SIZE_DELAY+2 bits.
  - test_delay saturates at 2^SIZE_DELAY-1 on overflow.
- FSM states: IDLE, SETTLE, MEASURE, REPORT, DONE.
- IDLE:
  - start=1 → SETTLE, with case_idx=0 and window count=0.
  - test_* outputs are driven from case 0 on the following cycle.
- SETTLE:
  - Counts SETTLE_CYCLES cycles, then goes to MEASURE.
  - The running peak is initialised to the most negative value, 1 followed by zeros.
- MEASURE:
  - Runs for exactly WINDOW_LEN cycles.
  - Each cycle, peak = max(peak, selected channel), using a signed compare.
  - After the last sample → REPORT.
- REPORT:
  - Lasts exactly one cycle.
  - peak_valid=1; peak_data and peak_case hold until the next REPORT.
  - Then:
    - If windows remain for this case → MEASURE; the peak re-initialises and there is no re-settle.
    - Else if case_idx<3 → case_idx increments → SETTLE; test_* update on entry.
    - Else → DONE.
- DONE:
  - done=1 for one cycle; test_* return to 0.
  - Next state is IDLE.
- Latency and rate:
  - First peak_valid arrives exactly 1+SETTLE_CYCLES+WINDOW_LEN cycles after the start cycle.
  - Subsequent windows in the same case follow every WINDOW_LEN+1 cycles.
- Abort:
  - abort=1 in any non-IDLE state → IDLE on the next cycle.
  - test_* are cleared and no peak_valid or done is issued.
  - abort has priority over all other transitions, including the REPORT strobe in the same cycle.
- start handling:
  - start while busy is ignored.
  - start and abort together in IDLE: abort wins and the block stays IDLE.
- filter_sel ≥ NUM_FILTERS selects channel 0.
- Reset mid-run behaves identically to abort, except that peak_data and peak_case are also cleared.

Optional Feature:
- Macro: FILTER_SEQ_MIN_TRACK_EN.
- When defined:
  - A parallel signed running minimum is kept, initialised to the most positive value.
  - It is updated in MEASURE and presented on min_data with the same timing as peak_data.
- When undefined:
  - No minimum logic is built; min_data is constant 0.

Test Plan:
- Reset released, start with base=10, step=5, windows=1, sel=2, constant channel-2 value 0x0100:
  - 4 peak_valid strobes, peak_data=0x0100, peak_case 0,1,2,3.
  - test_delay 10,15,20,25; overlay/rate follow 00,01,10,11.
  - done exactly once, then busy=0.
- Channel 2 ramps −300..+200 within window 0:
  - peak_data = 200 (0x00C8).
  - With FILTER_SEQ_MIN_TRACK_EN, min_data = −300 (0xFED4).
  - Check a negative-only window (all −5) gives peak_data = −5 (0xFFFB).
- base=250, step=3:
  - test_delay 250,253,255,255 (saturation); no wrap.
- windows=3:
  - 12 peak_valid total.
  - Spacing of 65 cycles within a case, and 1+32+64 cycles to the first strobe after start.
- abort during case 1 MEASURE:
  - busy falls next cycle; test_*=0; no further peak_valid; done never asserted.
  - A new start then runs all 4 cases normally.
- start pulses during busy, windows=0 and filter_sel=25:
  - Extra starts are ignored.
  - Each case produces 1 window.
  - Measurement uses channel 0.
